// File: rtl/md_unit_if.sv
// Request/response bundle between the E stage and the multiply/divide unit.
// The E stage drives the request side; the unit returns busy, stall_req and HI/LO.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       md_op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, md_op, A, B, input busy, stall_req, hi, lo);
    modport slave  (input start, md_op, A, B, output busy, stall_req, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Define MDU_MADD_EN to implement madd/maddu/msub/msubu (md_op 7-10); otherwise they are no-ops.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    md_unit_if.slave   bus
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_p_hi, w_p_hi_nxt;
    logic [WIDTH-1:0]   r_p_lo, w_p_lo_nxt;
    logic [WIDTH-1:0]   r_hi, w_hi_nxt;
    logic [WIDTH-1:0]   r_lo, w_lo_nxt;

    logic               w_is_mult, w_is_div, w_issue;
    logic [2*WIDTH-1:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
    logic [2*WIDTH-1:0] w_prod_s, w_prod_u, w_acc, w_result;
    logic               w_div_zero, w_div_ovf;
    logic [WIDTH-1:0]   w_sdiv_b, w_udiv_b;
    logic [WIDTH-1:0]   w_quot_s, w_rem_s, w_quot_u, w_rem_u;

    assign w_a_sx   = {{WIDTH{bus.A[WIDTH-1]}}, bus.A};
    assign w_b_sx   = {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
    assign w_a_zx   = {{WIDTH{1'b0}}, bus.A};
    assign w_b_zx   = {{WIDTH{1'b0}}, bus.B};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = w_a_zx * w_b_zx;
    assign w_acc    = {r_hi, r_lo};

    // Divisor forced to 1 on zero or MIN/-1: MIN/1 already yields lo=MIN, hi=0.
    assign w_div_zero = (bus.B == '0);
    assign w_div_ovf  = (bus.A == MIN_VAL) && (bus.B == ALL_ONES);
    assign w_sdiv_b   = (w_div_zero || w_div_ovf) ? ONE : bus.B;
    assign w_udiv_b   = w_div_zero ? ONE : bus.B;
    assign w_quot_s   = $signed(bus.A) / $signed(w_sdiv_b);
    assign w_rem_s    = $signed(bus.A) % $signed(w_sdiv_b);
    assign w_quot_u   = bus.A / w_udiv_b;
    assign w_rem_u    = bus.A % w_udiv_b;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_is_mult = 1'b0;
        w_is_div  = 1'b0;
        case (bus.md_op)
            OP_MULT, OP_MULTU:                    w_is_mult = 1'b1;
            OP_DIV, OP_DIVU:                      w_is_div  = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: w_is_mult = 1'b1;
`endif
            default: ;
        endcase
    end

    assign w_issue = bus.start && (w_is_mult || w_is_div);

    always_comb begin
        w_result = w_acc;
        case (bus.md_op)
            OP_MULT:  w_result = w_prod_s;
            OP_MULTU: w_result = w_prod_u;
            OP_DIV:   if (!w_div_zero) w_result = {w_rem_s, w_quot_s};
            OP_DIVU:  if (!w_div_zero) w_result = {w_rem_u, w_quot_u};
`ifdef MDU_MADD_EN
            OP_MADD:  w_result = w_acc + w_prod_s;
            OP_MADDU: w_result = w_acc + w_prod_u;
            OP_MSUB:  w_result = w_acc - w_prod_s;
            OP_MSUBU: w_result = w_acc - w_prod_u;
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_p_hi_nxt  = r_p_hi;
        w_p_lo_nxt  = r_p_lo;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt              = S_RUN;
                    w_cnt_nxt                = w_is_div ? DIV_LOAD : MULT_LOAD;
                    {w_p_hi_nxt, w_p_lo_nxt} = w_result;
                end else if (bus.start && bus.md_op == OP_MTHI) begin
                    w_hi_nxt = bus.A;
                end else if (bus.start && bus.md_op == OP_MTLO) begin
                    w_lo_nxt = bus.A;
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - CNT_LAST;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_hi_nxt    = r_p_hi;
                    w_lo_nxt    = r_p_lo;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_p_hi  <= '0;
            r_p_lo  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_p_hi  <= w_p_hi_nxt;
            r_p_lo  <= w_p_lo_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    assign bus.busy      = (r_state == S_RUN);
    assign bus.stall_req = bus.busy || w_issue;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a 64-bit arithmetic reference model checked every cycle,
// plus hand-computed HI/LO/busy expectations at the points the operations complete.
module tb_md_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_RSVD  = 4'd12;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    md_unit_if #(.WIDTH(W)) bus();

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit md_is_multi(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4: return 1'b1;
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Architectural result {hi,lo} of a multi-cycle op, computed with 64-bit integers.
    function automatic logic [63:0] md_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
        longint      sa, sb;
        logic [63:0] ua, ub, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        acc = {hi, lo};
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return ua * ub;
            4'd3: return (b == 0) ? acc : {32'(sa % sb), 32'(sa / sb)};
            4'd4: return (b == 0) ? acc : {32'(ua % ub), 32'(ua / ub)};
`ifdef MDU_MADD_EN
            4'd7:  return acc + 64'(sa * sb);
            4'd8:  return acc + ua * ub;
            4'd9:  return acc - 64'(sa * sb);
            4'd10: return acc - ua * ub;
`endif
            default: return acc;
        endcase
    endfunction

    int          m_left;
    logic [63:0] m_pend;
    logic [31:0] m_hi, m_lo;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_pend <= '0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else if (bus.start) begin
            if (md_is_multi(bus.md_op)) begin
                m_pend <= md_result(bus.md_op, bus.A, bus.B, m_hi, m_lo);
                m_left <= (bus.md_op == OP_DIV || bus.md_op == OP_DIVU) ? DC : MC;
            end else if (bus.md_op == OP_MTHI) begin
                m_hi <= bus.A;
            end else if (bus.md_op == OP_MTLO) begin
                m_lo <= bus.A;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("cyc_busy", 64'(bus.busy), 64'(m_left > 0));
            check("cyc_stall_req", 64'(bus.stall_req),
                  64'((m_left > 0) || (bus.start && md_is_multi(bus.md_op))));
            check("cyc_hi", 64'(bus.hi), 64'(m_hi));
            check("cyc_lo", 64'(bus.lo), 64'(m_lo));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(op, a, b);
        step();
        bus.start = 1'b0;
        bus.md_op = OP_NONE;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 200) begin
            step();
            cycles++;
        end
        check("wait_idle_timeout", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.md_op = OP_NONE;
        bus.A     = '0;
        bus.B     = '0;

        step();
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_stall_req", 64'(bus.stall_req), 64'(0));
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        step();
        reset = 1'b0;

        // Reset in the middle of a multiply discards the pending result.
        drive(OP_MULT, 32'd7, 32'd9);
        step();
        step();
        bus.start = 1'b0;
        bus.md_op = OP_NONE;
        check("pre_rst_busy", 64'(bus.busy), 64'(1));
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_hi", 64'(bus.hi), 64'(0));
        check("midrst_lo", 64'(bus.lo), 64'(0));
        step();
        reset = 1'b0;
        repeat (MC + 2) step();
        check("postrst_hi", 64'(bus.hi), 64'(0));
        check("postrst_lo", 64'(bus.lo), 64'(0));

        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check("mult_cycles", 64'(n), 64'(MC));
        check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);

        issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check("multu_hi", 64'(bus.hi), 64'h2);
        check("multu_lo", 64'(bus.lo), 64'hFFFF_FFFA);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_cycles", 64'(n), 64'(DC));
        check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("divovf_lo", 64'(bus.lo), 64'h8000_0000);
        check("divovf_hi", 64'(bus.hi), 64'h0);

        issue(OP_DIVU, 32'd5, 32'd0);
        wait_idle(n);
        check("div0_cycles", 64'(n), 64'(DC));
        check("div0_lo", 64'(bus.lo), 64'h8000_0000);
        check("div0_hi", 64'(bus.hi), 64'h0);

        issue(OP_MTHI, 32'h1234, 32'd0);
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        check("mthi_busy", 64'(bus.busy), 64'(0));

        issue(OP_RSVD, 32'd5, 32'd5);
        check("rsvd_busy", 64'(bus.busy), 64'(0));
        check("rsvd_hi", 64'(bus.hi), 64'h1234);

        // mtlo while a multiply is running must be dropped.
        issue(OP_MULT, 32'd3, 32'd4);
        issue(OP_MTLO, 32'hDEAD, 32'd0);
        check("mtlo_run_lo", 64'(bus.lo), 64'h8000_0000);
        wait_idle(n);
        check("mtlo_run_cycles", 64'(n), 64'(MC - 1));
        check("mtlo_run_final_lo", 64'(bus.lo), 64'd12);

        // Back-to-back issue in the first non-busy cycle.
        issue(OP_MULT, 32'd5, 32'd7);
        wait_idle(n);
        drive(OP_MULT, 32'd2, 32'd3);
        #1;
        check("b2b_stall_issue", 64'(bus.stall_req), 64'(1));
        check("b2b_first_lo", 64'(bus.lo), 64'd35);
        step();
        bus.start = 1'b0;
        bus.md_op = OP_NONE;
        check("b2b_second_busy", 64'(bus.busy), 64'(1));
        wait_idle(n);
        check("b2b_cycles", 64'(n), 64'(MC));
        check("b2b_lo", 64'(bus.lo), 64'd6);
        check("b2b_hi", 64'(bus.hi), 64'd0);

        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
        drive(OP_MADDU, 32'd1, 32'd1);
        #1;
`ifdef MDU_MADD_EN
        check("maddu_stall", 64'(bus.stall_req), 64'(1));
        step();
        bus.start = 1'b0;
        bus.md_op = OP_NONE;
        check("maddu_busy", 64'(bus.busy), 64'(1));
        wait_idle(n);
        check("maddu_cycles", 64'(n), 64'(MC));
        check("maddu_hi", 64'(bus.hi), 64'h1);
        check("maddu_lo", 64'(bus.lo), 64'h0);
`else
        check("maddu_stall", 64'(bus.stall_req), 64'(0));
        step();
        bus.start = 1'b0;
        bus.md_op = OP_NONE;
        check("maddu_busy", 64'(bus.busy), 64'(0));
        repeat (MC) step();
        check("maddu_hi", 64'(bus.hi), 64'h0);
        check("maddu_lo", 64'(bus.lo), 64'hFFFF_FFFF);
`endif

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with HI/LO registers, placed in the E stage of the five-stage pipeline alongside the ALU. It accepts mult/multu/div/divu/mthi/mtlo requests and runs each multi-cycle operation for a configurable latency. During that time it reports busy so the hazard unit can stall dependent instructions in D. mfhi/mflo read the HI/LO outputs combinationally through the normal E-stage result path.

## Interface
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for mult/multu/madd-family; legal range ≥1
- DIV_CYCLES, 10, busy cycles for div/divu; legal range ≥1
- Clock is `clk`; reset is `reset`. There is one clock. Reset is asynchronous and active-high.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  E-stage instruction is an MD operation; qualifies md_op
- md_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11–15 reserved
- A  in  WIDTH  forwarded rs value
- B  in  WIDTH  forwarded rt value
- busy  out  1  a multi-cycle operation is in flight
- stall_req  out  1  busy OR (start AND md_op ∈ {1–4, 7–10}); the HCU stalls any MD instruction in D while this is high
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- State: IDLE, RUN. Down-counter `cnt` is sized to hold max(MULT_CYCLES, DIV_CYCLES). Pending registers p_hi and p_lo are WIDTH bits each.
- IDLE with start and a multi-cycle op:
  - The result is computed from A and B at that edge and stored in p_hi/p_lo.
  - cnt loads MULT_CYCLES or DIV_CYCLES.
  - The state moves to RUN.
- mult: signed 2·WIDTH product, {hi,lo} ← A·B. multu is the same with unsigned operands.
- div:
  - Quotient goes to lo and remainder goes to hi.
  - The quotient truncates toward zero; the remainder takes the sign of A.
  - MIN/−1 gives lo = MIN, hi = 0.
  - divu is unsigned.
- Divide by zero (div or divu with B = 0): busy runs the full DIV_CYCLES, then hi and lo keep their old values.
- madd family: {hi,lo} ± product, using the HI/LO values at the start edge. The sum wraps modulo 2^(2·WIDTH).
- mthi/mtlo in IDLE: hi ← A or lo ← A at the next edge. busy is not asserted.
- RUN:
  - cnt decrements each cycle.
  - On the edge where cnt = 1: hi ← p_hi, lo ← p_lo, state returns to IDLE.
- start during RUN (any op, including mthi/mtlo) is ignored. The pipeline must prevent this; the bench checks that state is unchanged.
- md_op 0 or reserved with start: no-op.
- reset asserted at any time: state IDLE, busy 0, cnt 0, hi 0, lo 0, pending results discarded.

## Timing
- Reset values: busy 0, stall_req 0 (when start = 0), hi 0, lo 0.
- Issue at edge T0: busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), from after T0 to the edge T0+N.
- New hi/lo are visible from T0+N, the first cycle in which busy is low.
- During the busy window, hi/lo hold their pre-issue values; there is no partial update.
- A back-to-back issue is accepted in the first cycle busy is low. Zero dead cycles between operations.
- stall_req is combinational from start/md_op/busy. busy, hi and lo are registered.

## Configuration
- MDU_MADD_EN defined: md_op 7–10 are implemented as specified above.
- MDU_MADD_EN undefined: md_op 7–10 are treated as reserved no-ops.
  - No busy, no hi/lo change, stall_req not raised by them.
  - The accumulate datapath is removed.

## Test plan
- Reset: drive start with mult for 2 cycles, then assert reset mid-RUN -> busy 0, hi 0, lo 0 immediately; no update afterwards.
- mult A=0xFFFFFFFE (−2), B=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. With multu on the same operands -> hi=0x2, lo=0xFFFFFFFA.
- div A=−7, B=2 -> busy high 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. div A=0x80000000, B=−1 -> lo=0x80000000, hi=0. divu with B=0 after the above -> hi/lo unchanged after 10 cycles.
- mthi A=0x1234 with start in IDLE -> hi=0x1234 next cycle, busy stays 0. mtlo with start during RUN -> ignored, lo unchanged.
- Back-to-back: mult issued, then a second mult in the first cycle busy is low -> accepted. stall_req high throughout both runs and in each issue cycle.
- With MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, then maddu A=1, B=1 -> hi=1, lo=0 after 5 cycles. With MDU_MADD_EN undefined: same stimulus -> no busy, hi/lo unchanged.
